// File: rtl/cbd_sampler_if.sv
// ----------------------------------------------------------------------------
// cbd_sampler_if
//   Coefficient stream from the CBD sampler to the NTT/polynomial buffer.
//   Handshake: a beat transfers on a rising clock edge where coeff_valid and
//   coeff_ready are both high; while coeff_valid is high and coeff_ready is
//   low, coeff and coeff_idx hold their values.
//   Signals:
//     coeff_valid  master->slave  coeff/coeff_idx carry a coefficient
//     coeff_ready  slave->master  downstream can take the beat
//     coeff        master->slave  coefficient, 0..Q-1
//     coeff_idx    master->slave  coefficient index, 0..255
// ----------------------------------------------------------------------------
interface cbd_sampler_if #(
   parameter int CW = 12
);
   logic          coeff_valid;
   logic          coeff_ready;
   logic [CW-1:0] coeff;
   logic [7:0]    coeff_idx;

   modport master (
      output coeff_valid,
      output coeff,
      output coeff_idx,
      input  coeff_ready
   );

   modport slave (
      input  coeff_valid,
      input  coeff,
      input  coeff_idx,
      output coeff_ready
   );
endinterface

// File: rtl/cbd_sampler.sv
// ----------------------------------------------------------------------------
// cbd_sampler
//   Expands a latched PRF byte string Z into the 256 centred-binomial noise
//   coefficients (eta=3 or eta=2), reduced mod Q, and streams them out one per
//   accepted beat.
//   Ports:
//     clk        clock, rising edge
//     rst        asynchronous active-low reset
//     start      pulse: latch Z and n_num (ignored unless IDLE)
//     n_num      1 => eta=3, 2 => eta=2, 0/3 illegal (err pulse)
//     Z          PRF output, Z[0] is the first stream bit
//     cbus       coefficient stream (master side)
//     busy       high while not IDLE
//     done       one-cycle pulse after the last coefficient is accepted
//     err        one-cycle pulse after a start with illegal n_num
//     state_dbg  current FSM state
// ----------------------------------------------------------------------------
module cbd_sampler #(
   parameter int Q      = 3329,
   parameter int N_COEF = 256,
   parameter int Z_W    = 1536,
   parameter int CW     = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       n_num,
   input  logic [0:Z_W-1]   Z,
   cbd_sampler_if.master    cbus,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [7:0] LAST_IDX = 8'(N_COEF - 1);

   state_t         state;
   state_t         state_nx;
   // Z is consumed from index 0 upward; shifting left brings the next
   // coefficient's bit group to the front of the buffer.
   logic [0:Z_W-1] zbuf;
   logic           eta3;
   logic [7:0]     idx;
   logic           err_q;

   logic           accept;
   logic           start_ok;
   logic           start_bad;
   logic [1:0]     sum_a;
   logic [1:0]     sum_b;
   logic [CW-1:0]  coeff_mod;

   assign accept    = (state == S_RUN) && cbus.coeff_ready;
   assign start_ok  = (state == S_IDLE) && start && ((n_num == 2'd1) || (n_num == 2'd2));
   assign start_bad = (state == S_IDLE) && start && ((n_num == 2'd0) || (n_num == 2'd3));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start_ok) state_nx = S_RUN;
         S_RUN:   if (accept && (idx == LAST_IDX)) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         zbuf  <= '0;
         eta3  <= 1'b0;
         idx   <= '0;
         err_q <= 1'b0;
      end else begin
         err_q <= start_bad;
         if (start_ok) begin
            zbuf <= Z;
            eta3 <= (n_num == 2'd1);
            idx  <= '0;
         end else if (accept) begin
            // eta=2 advances 4 bits per coefficient, so after 256 beats only
            // Z[0:1023] has passed through the window.
            zbuf <= eta3 ? (zbuf << 6) : (zbuf << 4);
            // The counter parks at the last index; leaving RUN is the only exit.
            if (idx != LAST_IDX) idx <= idx + 8'd1;
         end
      end
   end

   // a = first eta bits of the group, b = following eta bits.
   always_comb begin
      sum_a     = 2'd0;
      sum_b     = 2'd0;
      coeff_mod = '0;
      if (eta3) begin
         sum_a = 2'(zbuf[0]) + 2'(zbuf[1]) + 2'(zbuf[2]);
         sum_b = 2'(zbuf[3]) + 2'(zbuf[4]) + 2'(zbuf[5]);
      end else begin
         sum_a = 2'(zbuf[0]) + 2'(zbuf[1]);
         sum_b = 2'(zbuf[2]) + 2'(zbuf[3]);
      end
      if (sum_a >= sum_b) begin
         coeff_mod = CW'(sum_a - sum_b);
      end else begin
         coeff_mod = CW'(Q) - CW'(sum_b - sum_a);
      end
   end

   assign cbus.coeff_valid = (state == S_RUN);
   assign cbus.coeff       = (state == S_RUN) ? coeff_mod : '0;
   assign cbus.coeff_idx   = (state == S_RUN) ? idx : '0;
   assign busy             = (state != S_IDLE);
   assign done             = (state == S_DONE);
   assign err              = err_q;
   assign state_dbg        = state;

endmodule

// File: tb/tb_cbd_sampler.sv
module tb_cbd_sampler;
   localparam int Q   = 3329;
   localparam int Z_W = 1536;
   localparam int CW  = 12;

   logic             clk   = 1'b0;
   logic             rst   = 1'b0;
   logic             start = 1'b0;
   logic [1:0]       n_num = 2'd0;
   logic [0:Z_W-1]   z     = '0;
   logic             busy;
   logic             done;
   logic             err;
   logic [1:0]       state_dbg;

   cbd_sampler_if #(.CW(CW)) cif ();

   cbd_sampler dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .n_num     (n_num),
      .Z         (z),
      .cbus      (cif),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .state_dbg (state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // scoreboard: {idx[7:0], coeff[11:0]}
   logic [19:0] exp_q[$];

   function automatic logic [0:Z_W-1] make_z(input int eta, input logic [5:0] pat);
      logic [0:Z_W-1] r;
      r = '0;
      for (int i = 0; i < 256; i++)
         for (int j = 0; j < 2 * eta; j++)
            r[2 * eta * i + j] = pat[2 * eta - 1 - j];
      return r;
   endfunction

   function automatic logic [0:Z_W-1] rand_z();
      logic [0:Z_W-1] r;
      r = '0;
      for (int k = 0; k < Z_W; k += 32) r[k +: 32] = $urandom();
      return r;
   endfunction

   function automatic int model_coeff(input logic [0:Z_W-1] zz, input int eta, input int i);
      int a;
      int b;
      a = 0;
      b = 0;
      for (int j = 0; j < eta; j++) begin
         a += int'(zz[2 * eta * i + j]);
         b += int'(zz[2 * eta * i + eta + j]);
      end
      return (a >= b) ? (a - b) : (Q + a - b);
   endfunction

   task automatic push_model(input logic [0:Z_W-1] zz, input int eta);
      for (int i = 0; i < 256; i++) exp_q.push_back({8'(i), 12'(model_coeff(zz, eta, i))});
   endtask

   task automatic push_const(input int val);
      for (int i = 0; i < 256; i++) exp_q.push_back({8'(i), 12'(val)});
   endtask

   // driver: start a run and consume the stream, comparing every beat
   task automatic run_stream(input logic [1:0] nn, input logic [0:Z_W-1] zz,
                             input int stall_idx, input int stall_len,
                             input bit poke_start, input int abort_idx, input string name);
      int cyc;
      int beats;
      int stalls;
      bit aborted;
      logic [19:0] e;
      cyc = 0;
      beats = 0;
      stalls = 0;
      aborted = 1'b0;
      @(negedge clk);
      z = zz;
      n_num = nn;
      start = 1'b1;
      cif.coeff_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      z = ~zz;        // inputs changing after the start cycle must not matter
      n_num = 2'd0;
      while (beats < 256 && cyc < 4000 && !aborted) begin
         cyc++;
         e = exp_q[0];
         checks++;
         if (cif.coeff_valid !== 1'b1 || cif.coeff_idx !== e[19:12] ||
             cif.coeff !== e[11:0] || err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s beat: valid=%b idx=%0d coeff=%0d err=%b busy=%b, required valid=1 idx=%0d coeff=%0d err=0 busy=1",
                     name, cif.coeff_valid, cif.coeff_idx, cif.coeff, err, busy, e[19:12], e[11:0]);
         end
         if (abort_idx >= 0 && beats == abort_idx) begin
            #2 rst = 1'b0;
            #1;
            checks++;
            if (cif.coeff_valid !== 1'b0 || cif.coeff !== '0 || cif.coeff_idx !== 8'd0 ||
                busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || state_dbg !== 2'd0) begin
               errors++;
               $display("FAIL %s async_reset: valid=%b coeff=%0d idx=%0d busy=%b done=%b err=%b state=%0d, required all 0",
                        name, cif.coeff_valid, cif.coeff, cif.coeff_idx, busy, done, err, state_dbg);
            end
            exp_q.delete();
            aborted = 1'b1;
         end else if (beats == stall_idx && stalls < stall_len) begin
            cif.coeff_ready = 1'b0;
            stalls++;
            if (poke_start) begin
               start = 1'b1;
               n_num = 2'd3;
               z = '1;
            end
         end else begin
            cif.coeff_ready = 1'b1;
            start = 1'b0;
            void'(exp_q.pop_front());
            beats++;
         end
         @(negedge clk);
      end
      if (aborted) begin
         repeat (3) begin
            checks++;
            if (done !== 1'b0 || cif.coeff_valid !== 1'b0 || busy !== 1'b0) begin
               errors++;
               $display("FAIL %s in_reset: done=%b valid=%b busy=%b, required 0 0 0",
                        name, done, cif.coeff_valid, busy);
            end
            @(negedge clk);
         end
         rst = 1'b1;
      end else if (beats < 256) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: beats=%0d, required 256", name, beats);
      end else begin
         checks++;
         if (done !== 1'b1 || cif.coeff_valid !== 1'b0 || cif.coeff !== '0 ||
             cif.coeff_idx !== 8'd0 || busy !== 1'b1 || state_dbg !== 2'd2) begin
            errors++;
            $display("FAIL %s done_cycle: done=%b valid=%b coeff=%0d idx=%0d busy=%b state=%0d, required 1 0 0 0 1 2",
                     name, done, cif.coeff_valid, cif.coeff, cif.coeff_idx, busy, state_dbg);
         end
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || cif.coeff_valid !== 1'b0 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL %s back_to_idle: done=%b busy=%b valid=%b state=%0d, required 0 0 0 0",
                     name, done, busy, cif.coeff_valid, state_dbg);
         end
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (cif.coeff_valid !== 1'b0 || cif.coeff !== '0 || cif.coeff_idx !== 8'd0 ||
          busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || state_dbg !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: valid=%b coeff=%0d idx=%0d busy=%b done=%b err=%b state=%0d, required all 0",
                  cif.coeff_valid, cif.coeff, cif.coeff_idx, busy, done, err, state_dbg);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_all_zero();
      push_const(0);
      run_stream(2'd2, '0, -1, 0, 1'b0, -1, "t1_zero_eta2");
   endtask

   task automatic test_patterns();
      push_const(3);
      run_stream(2'd1, make_z(3, 6'b111000), -1, 0, 1'b0, -1, "t2_eta3_111000");
      push_const(3326);
      run_stream(2'd1, make_z(3, 6'b000111), -1, 0, 1'b0, -1, "t2_eta3_000111");
      push_const(3328);
      run_stream(2'd1, make_z(3, 6'b100110), -1, 0, 1'b0, -1, "t2_eta3_100110");
      push_const(2);
      run_stream(2'd2, make_z(2, 6'b001100), -1, 0, 1'b0, -1, "t2_eta2_1100");
      push_const(3327);
      run_stream(2'd2, make_z(2, 6'b000011), -1, 0, 1'b0, -1, "t2_eta2_0011");
   endtask

   task automatic test_upper_unused();
      logic [0:Z_W-1] zz;
      zz = '0;
      for (int k = 1024; k < Z_W; k++) zz[k] = 1'b1;
      push_const(0);
      run_stream(2'd2, zz, -1, 0, 1'b0, -1, "t3_upper_unused");
   endtask

   task automatic test_random();
      logic [0:Z_W-1] zz;
      zz = rand_z();
      push_model(zz, 3);
      run_stream(2'd1, zz, -1, 0, 1'b0, -1, "rand_eta3");
      zz = rand_z();
      push_model(zz, 2);
      run_stream(2'd2, zz, -1, 0, 1'b0, -1, "rand_eta2");
   endtask

   task automatic test_backpressure();
      logic [0:Z_W-1] zz;
      zz = rand_z();
      push_model(zz, 3);
      run_stream(2'd1, zz, 10, 5, 1'b1, -1, "t4_backpressure");
      zz = rand_z();
      push_model(zz, 2);
      run_stream(2'd2, zz, $urandom_range(0, 255), $urandom_range(1, 8), 1'b1, -1, "t4_rand_stall");
   endtask

   task automatic test_err(input logic [1:0] nn);
      @(negedge clk);
      start = 1'b1;
      n_num = nn;
      z = rand_z();
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || cif.coeff_valid !== 1'b0) begin
         errors++;
         $display("FAIL t5_err_pulse n_num=%0d: err=%b busy=%b valid=%b, required 1 0 0",
                  nn, err, busy, cif.coeff_valid);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || busy !== 1'b0 || cif.coeff_valid !== 1'b0 || state_dbg !== 2'd0) begin
         errors++;
         $display("FAIL t5_err_clear n_num=%0d: err=%b busy=%b valid=%b state=%0d, required 0 0 0 0",
                  nn, err, busy, cif.coeff_valid, state_dbg);
      end
   endtask

   task automatic test_async_reset();
      logic [0:Z_W-1] zz;
      zz = rand_z();
      push_model(zz, 3);
      run_stream(2'd1, zz, -1, 0, 1'b0, 100, "t6_abort");
      zz = rand_z();
      push_model(zz, 2);
      run_stream(2'd2, zz, -1, 0, 1'b0, -1, "t6_restart");
   endtask

   initial begin
      cif.coeff_ready = 1'b0;
      test_reset();
      test_all_zero();
      test_patterns();
      test_upper_unused();
      test_random();
      test_backpressure();
      test_err(2'd0);
      test_err(2'd3);
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
